// File: rtl/prng_chunk_server.sv
// ---------------------------------------------------------------------------
// prng_chunk_server
//
// Producer end of the Gaussian sampler's RNG interface. Pairs of 64-bit
// words from the SHAKE256 squeeze stream are packed into 128-bit chunks
// (first word in bits 63:0) and buffered in a DEPTH-entry FIFO. The FIFO
// head is presented on rng and released when the sampler extracts it.
//
// Parameters:
//   DEPTH          FIFO depth in 128-bit chunks (power of two, >= 2)
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   ena            enable; low flushes all buffered state at the next edge
//   shake_valid    upstream word valid
//   shake_data     upstream 64-bit word
//   shake_ready    word accepted this cycle (ena high and FIFO not full)
//   rng_extract    sampler consumes the current chunk this cycle
//   rng_valid      a chunk is available on rng
//   rng            current chunk (FIFO head)
//   chunks_served  pop counter, modulo 2^32 (only with PRNG_CHUNK_CNT_EN)
//
// Configuration macro:
//   PRNG_CHUNK_CNT_EN  when defined, adds the chunks_served output/counter.
// ---------------------------------------------------------------------------
module prng_chunk_server #(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic         shake_valid,
    input  logic [63:0]  shake_data,
    output logic         shake_ready,
    input  logic         rng_extract,
    output logic         rng_valid,
    output logic [127:0] rng
`ifdef PRNG_CHUNK_CNT_EN
    ,
    output logic [31:0]  chunks_served
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic           half_q,   half_d;
    logic [63:0]    lo_q,     lo_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic [127:0]   mem_q [DEPTH];

    logic           accept_s;
    logic           push_s;
    logic           pop_s;
    logic           wr_en_s;
    logic [127:0]   wr_data_s;

    // Handshake and FIFO status, all derived from registered state.
    always_comb begin
        shake_ready = ena && (count_q != FULL_CNT);
        rng_valid   = (count_q != {CW{1'b0}});
        rng         = mem_q[rd_ptr_q];
        accept_s    = shake_valid && shake_ready;
        // The second word of a pair completes a chunk and pushes it.
        push_s      = accept_s && half_q;
        pop_s       = rng_extract && rng_valid;
        wr_en_s     = push_s;
        wr_data_s   = {shake_data, lo_q};
    end

    // Next-state logic for packer, pointers and occupancy.
    always_comb begin
        half_d   = half_q;
        lo_d     = lo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (!ena) begin
            // Flush: a half-packed word is dropped along with all chunks.
            // lo is left alone; it is overwritten before it can be used.
            half_d   = 1'b0;
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (accept_s) begin
                if (half_q) begin
                    half_d   = 1'b0;
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end else begin
                    lo_d   = shake_data;
                    half_d = 1'b1;
                end
            end else begin
                half_d = half_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            half_q   <= 1'b0;
            lo_q     <= 64'h0;
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            half_q   <= half_d;
            lo_q     <= lo_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Chunk storage; cleared on reset so rng reads zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 128'h0;
            end
        end else if (wr_en_s) begin
            mem_q[wr_ptr_q] <= wr_data_s;
        end
    end

`ifdef PRNG_CHUNK_CNT_EN
    logic [31:0] served_q, served_d;

    // Pop counter next state; wraps naturally at 2^32.
    always_comb begin
        served_d = served_q;
        if (!ena) begin
            served_d = 32'h0;
        end else if (pop_s) begin
            served_d = served_q + 32'd1;
        end else begin
            served_d = served_q;
        end
    end

    // Pop counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            served_q <= 32'h0;
        end else begin
            served_q <= served_d;
        end
    end

    assign chunks_served = served_q;
`endif

endmodule
